// File: rtl/vga_cfg_bank.sv
// vga_cfg_bank: SPI-fed shadow/active configuration register bank for the VGA GPU.
// Shadow writes commit at frame_start; define VGA_CFG_IMMEDIATE_EN to enable bit6 immediate writes.
module vga_cfg_bank #(
  parameter int NUM_REGS = 4,
  parameter int REG_W = 32,
  parameter int ADDR_W = 4,
  parameter logic [REG_W-1:0] RST_VAL0 = REG_W'(32'hBFFC_0000)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      cs_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic                      frame_start,
  output logic [NUM_REGS*REG_W-1:0] cfg_flat,
  output logic [NUM_REGS-1:0]       pending,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  output logic [1:0]                dbg_state
);

  // Handshake: rx_valid and tx_valid are single-cycle qualifiers with no back-pressure;
  // a byte is consumed on every cycle rx_valid is high, and tx_data is new when tx_valid is high.
  localparam int NB = REG_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, RDATA = 2'd2, DRAIN = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [REG_W-1:0]    active_q [NUM_REGS];
  logic [REG_W-1:0]    shadow_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [REG_W-1:0]    staging_q;
  logic [REG_W-1:0]    wval;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                cmd_fire, wr_byte, wr_fire, rd_step, rd_done;
`ifdef VGA_CFG_IMMEDIATE_EN
  logic                imm_q;
`endif

  // Byte idx of the active register at address a; unmapped addresses read as zero.
  function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] idx);
    logic [REG_W-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) sel = active_q[i];
    sel = sel >> {idx, 3'b000};
    return sel[7:0];
  endfunction

  assign wval = (staging_q << 8) | REG_W'(rx_data);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cmd_fire = 1'b0;
    wr_byte  = 1'b0;
    wr_fire  = 1'b0;
    rd_step  = 1'b0;
    rd_done  = 1'b0;
    if (ena) begin
      if (cs_n) begin
        state_d = IDLE;
      end else if (rx_valid) begin
        case (state_q)
          IDLE: begin
            cmd_fire = 1'b1;
            state_d  = rx_data[7] ? WDATA : RDATA;
          end
          WDATA: begin
            wr_byte = 1'b1;
            if (cnt_q == LAST) begin
              wr_fire = 1'b1;
              state_d = DRAIN;
            end
          end
          RDATA: begin
            if (cnt_q == LAST) begin
              rd_done = 1'b1;
              state_d = DRAIN;
            end else begin
              rd_step = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      staging_q  <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`ifdef VGA_CFG_IMMEDIATE_EN
      imm_q      <= 1'b0;
`endif
    end else begin
      tx_valid_q <= 1'b0;
      if (ena) begin
        if (cs_n) begin
          staging_q <= '0;
          cnt_q     <= '0;
          tx_data_q <= 8'h00;
        end else begin
          if (cmd_fire) begin
            addr_q    <= rx_data[ADDR_W-1:0];
            cnt_q     <= '0;
            staging_q <= '0;
`ifdef VGA_CFG_IMMEDIATE_EN
            imm_q     <= rx_data[6];
`endif
            // A read presents its MSB in the cycle right after the command byte.
            if (!rx_data[7]) begin
              tx_data_q  <= rd_byte(rx_data[ADDR_W-1:0], LAST);
              tx_valid_q <= 1'b1;
            end else begin
              tx_data_q  <= 8'h00;
            end
          end
          if (wr_byte) begin
            staging_q <= wval;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
          if (rd_step) begin
            tx_data_q  <= rd_byte(addr_q, LAST - cnt_q - CNT_W'(1));
            tx_valid_q <= 1'b1;
            cnt_q      <= cnt_q + CNT_W'(1);
          end
          if (rd_done) tx_data_q <= 8'h00;
        end
      end
    end
  end

  // Commit sees pre-write shadow/pending, so a write landing with frame_start stays pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_q[i] <= (i == 0) ? RST_VAL0 : '0;
        shadow_q[i] <= (i == 0) ? RST_VAL0 : '0;
      end
      pending_q <= '0;
    end else if (ena) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (frame_start && pending_q[i]) begin
          active_q[i]  <= shadow_q[i];
          pending_q[i] <= 1'b0;
        end
        if (wr_fire && addr_q == ADDR_W'(i)) begin
          shadow_q[i] <= wval;
`ifdef VGA_CFG_IMMEDIATE_EN
          if (imm_q) begin
            active_q[i]  <= wval;
            pending_q[i] <= 1'b0;
          end else begin
            pending_q[i] <= 1'b1;
          end
`else
          pending_q[i] <= 1'b1;
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_flat[g*REG_W +: REG_W] = active_q[g];
  end

  assign pending   = pending_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign dbg_state = state_q;

endmodule

// File: doc/vga_cfg_bank.md
Name: vga_cfg_bank

Overview:
- Multi-register configuration bank for the VGA GPU, fed by the SPI peripheral's received-byte stream.
- Replaces the single 32-bit configuration register with NUM_REGS shadow/active register pairs.
- Shadow writes commit to the active copies only at frame start, so pixel-mux mode, colour and char settings never change mid-frame.
- Supports byte-serial readback of the active registers.

Parameters:
- NUM_REGS, 4, number of configuration registers (2..16).
- REG_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 4, address field width in the command byte (NUM_REGS <= 2**ADDR_W, ADDR_W <= 6).
- RST_VAL0, 32'hBFFC_0000, reset value of register 0; all other registers reset to 0.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  block enable; when low, rx_valid and frame_start are ignored and all state holds
- cs_n  in  1  SPI chip select (synchronised upstream); high aborts any transaction
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte
- rx_data  in  8  received byte
- frame_start  in  1  one-cycle pulse at start of vertical blank (from timing generator)
- cfg_flat  out  NUM_REGS*REG_W  active registers; reg i at [i*REG_W +: REG_W]
- pending  out  NUM_REGS  per-register dirty flag: shadow differs from active, not yet committed
- tx_data  out  8  next byte to shift out on MISO
- tx_valid  out  1  one-cycle pulse: tx_data updated

Behaviour:
- Reset:
  - active and shadow reg0 = RST_VAL0, others 0.
  - pending = 0, tx_data = 0, tx_valid = 0, FSM = IDLE, byte counter = 0.
- Transaction format:
  - Command byte: bit7 = 1 write / 0 read; bit6 = immediate (see Optional Feature); bits[ADDR_W-1:0] = address; unused bits ignored.
  - Followed by NB = REG_W/8 data bytes, MSB first.
- FSM states: IDLE, WDATA, RDATA, DRAIN.
  - IDLE + rx_valid: latch address; bit7 = 1 -> WDATA, else RDATA; byte counter = 0.
  - WDATA: each rx_valid shifts rx_data into the staging register, count++.
    - On byte NB: write staging to shadow[addr], set pending[addr], -> DRAIN.
  - RDATA:
    - On entry (the cycle after the command byte), tx_data = active[addr] byte NB-1 and tx_valid pulses.
    - Each subsequent rx_valid presents the next lower byte with tx_valid one cycle after rx_valid.
    - After the byte 0 exchange -> DRAIN.
  - DRAIN: further bytes are ignored; tx_data = 0x00.
- cs_n high in any state:
  - FSM -> IDLE next cycle and the staging register is discarded.
  - No shadow write occurs for a partial write.
- Address >= NUM_REGS:
  - The write completes its byte count, but shadow and pending are unchanged.
  - A read returns 0x00 for every byte.
- Commit:
  - On frame_start && ena: for each i with pending[i] = 1, active[i] <= shadow[i] and pending[i] cleared.
  - cfg_flat reflects the new values the cycle after frame_start.
- Same-cycle final write byte and frame_start:
  - Commit uses the pre-write shadow/pending.
  - The new write stays pending (pending[addr] = 1) until the next frame_start.
- Rewriting a pending register before commit overwrites shadow; only the last value commits.
- Readback always returns active values, never shadow.
- Throughput: rx_valid may assert every cycle; no back-pressure.

Optional Feature:
- Macro: VGA_CFG_IMMEDIATE_EN.
- Defined: a write command with bit6 = 1 updates shadow[addr] and active[addr] together on the final byte, and pending[addr] is cleared.
  - If frame_start coincides with that cycle, the immediate value wins for that register.
- Undefined: bit6 is ignored and all writes are frame-synchronous.

Test Plan:
- Reset: rst_n low 2 cycles -> cfg_flat[31:0] = 0xBFFC0000, other regs 0, pending = 0, tx_valid = 0.
- Write reg1: bytes 0x81,0x12,0x34,0x56,0x78 -> pending = 4'b0010, cfg_flat[63:32] = 0. After frame_start -> cfg_flat[63:32] = 0x12345678, pending = 0.
- Read reg0 after reset: command 0x00, then 4 dummy bytes -> tx_data sequence 0xBF,0xFC,0x00,0x00, one tx_valid each, then 0x00 in DRAIN.
- Abort: 0x82,0xAA,0xBB, then cs_n high -> pending = 0, shadow[2] unchanged. Next transaction parses a fresh command byte.
- Collision: final byte of a reg3 write (0xDEADBEEF) on the same cycle as frame_start -> reg3 unchanged and pending[3] = 1. Next frame_start -> reg3 = 0xDEADBEEF.
- Out-of-range / immediate:
  - Write to address 9 with NUM_REGS = 4 -> no change.
  - With VGA_CFG_IMMEDIATE_EN, 0xC0 + 0x01020304 -> cfg_flat[31:0] = 0x01020304 the cycle after the final byte, with no frame_start.
